// File: rtl/clock_gate_ctrl.sv
// Enable-side controller for the core clock gate: drains, holds, gates and re-wakes the
// core domain from the free-running clock, and measures how long each sleep lasted.
module clock_gate_ctrl #(
    parameter int IDLE_HOLD  = 4,
    parameter int WAKE_DELAY = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sleep_req_i,
    input  logic             wake_req_i,
    input  logic             busy_i,
    input  logic             scan_en_i,
    output logic             gate_en_o,
    output logic             sleep_ack_o,
    output logic             awake_o,
    output logic [CNT_W-1:0] sleep_cycles_o,
    output logic [2:0]       dbg_state
);

    // sleep_req_i/wake_req_i are levels, not pulses: sleep_ack_o stays 1 for as long as the
    // clock is gated and awake_o stays 1 for as long as the domain is usable.

    localparam int MAX_CNT = (IDLE_HOLD > WAKE_DELAY) ? IDLE_HOLD : WAKE_DELAY;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] HOLD_INIT = CW'(IDLE_HOLD - 1);
    localparam logic [CW-1:0] WAKE_INIT = CW'(WAKE_DELAY - 1);
    localparam logic [CNT_W-1:0] CYC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_DRAIN = 3'd1,
        S_HOLD  = 3'd2,
        S_SLEEP = 3'd3,
        S_WAKE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gate_en_q;
    logic              sleep_ack_q;
    logic              awake_q;
    logic [CNT_W-1:0]  sleep_cycles_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // In DRAIN/HOLD an abort (wake or dropped request) beats busy, which beats the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (sleep_req_i && !wake_req_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wake_req_i || !sleep_req_i) begin
                    state_d = S_RUN;
                end else if (!busy_i) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            S_HOLD: begin
                if (wake_req_i || !sleep_req_i) begin
                    state_d = S_RUN;
                end else if (busy_i) begin
                    state_d = S_DRAIN;
                end else if (cnt_q == '0) begin
                    state_d = S_SLEEP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SLEEP: begin
                if (wake_req_i) begin
                    state_d = S_WAKE;
                    cnt_d   = WAKE_INIT;
                end
            end
            S_WAKE: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_RUN;
        endcase
    end

    // Outputs are flopped from the next state so they switch on the edge that enters the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_en_q   <= 1'b1;
            sleep_ack_q <= 1'b0;
            awake_q     <= 1'b1;
        end else begin
            gate_en_q   <= (state_d != S_SLEEP);
            sleep_ack_q <= (state_d == S_SLEEP);
            awake_q     <= (state_d == S_RUN);
        end
    end

    // The cycle that enters SLEEP zeroes the count; every cycle spent in SLEEP adds one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sleep_cycles_q <= '0;
        end else if (state_q == S_SLEEP) begin
            if (!(&sleep_cycles_q)) sleep_cycles_q <= sleep_cycles_q + CYC_ONE;
        end else if (state_d == S_SLEEP) begin
            sleep_cycles_q <= '0;
        end
    end

    assign gate_en_o      = gate_en_q | scan_en_i;
    assign sleep_ack_o    = sleep_ack_q;
    assign awake_o        = awake_q;
    assign sleep_cycles_o = sleep_cycles_q;
    assign dbg_state      = state_q;

endmodule
